// File: rtl/add8_frame_accumulator_if.sv
// Handshake bundle between the adder datapath, the frame accumulator and the result sink.
interface add8_frame_accumulator_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_s;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_s, in_cout, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_s, in_cout, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/add8_frame_accumulator.sv
// Sums COUNT 9-bit adder results {cout,s} into one frame total with a sticky wrap flag.
// Total is presented on out_valid right after the last accept; one idle bubble after the handshake.
module add8_frame_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  output logic                    busy_o,
  add8_frame_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign addend  = ACC_W'({bus.in_cout, bus.in_s});
  assign sum     = {1'b0, acc_q} + {1'b0, addend};
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign accept  = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = addend;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (COUNT == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum[ACC_W];
          if (cnt_inc == CNT_W'(COUNT)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over both a pending accept and a pending output handshake.
    if (clear_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = (state_q == HOLD) ? acc_q : '0;
  assign bus.out_ovf   = (state_q == HOLD) ? ovf_q : 1'b0;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_add8_frame_accumulator.sv
// Drives three accumulator configurations with shared stimulus and checks them against a frame-level model.
module tb_add8_frame_accumulator;
  localparam int CNT_P [3] = '{4, 4, 1};
  localparam int W_P   [3] = '{16, 10, 16};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_s;
  logic       in_cout;
  logic       out_ready;
  logic       busy [3];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int              n_m    [3];
  longint unsigned tot_m  [3];
  bit              pend_m [3];

  always #5 clk = ~clk;

  add8_frame_accumulator_if #(.ACC_W(16)) if0 ();
  add8_frame_accumulator_if #(.ACC_W(10)) if1 ();
  add8_frame_accumulator_if #(.ACC_W(16)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_s = in_s;          assign if1.in_s = in_s;          assign if2.in_s = in_s;
  assign if0.in_cout = in_cout;    assign if1.in_cout = in_cout;    assign if2.in_cout = in_cout;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  add8_frame_accumulator #(.COUNT(4), .ACC_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .busy_o(busy[0]), .bus(if0));
  add8_frame_accumulator #(.COUNT(4), .ACC_W(10)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .busy_o(busy[1]), .bus(if1));
  add8_frame_accumulator #(.COUNT(1), .ACC_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .busy_o(busy[2]), .bus(if2));

  logic        o_rdy [3];
  logic        o_vld [3];
  logic        o_ovf [3];
  logic [15:0] o_sum [3];

  assign o_rdy[0] = if0.in_ready;  assign o_rdy[1] = if1.in_ready;  assign o_rdy[2] = if2.in_ready;
  assign o_vld[0] = if0.out_valid; assign o_vld[1] = if1.out_valid; assign o_vld[2] = if2.out_valid;
  assign o_ovf[0] = if0.out_ovf;   assign o_ovf[1] = if1.out_ovf;   assign o_ovf[2] = if2.out_ovf;
  assign o_sum[0] = if0.out_sum;   assign o_sum[1] = {6'd0, if1.out_sum}; assign o_sum[2] = if2.out_sum;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      n_m[i] = 0;
      tot_m[i] = 0;
      pend_m[i] = 1'b0;
    end
  endtask

  // A frame is a list of accepted addends; wrap happened iff the integer total reached 2^W.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        n_m[i] = 0; tot_m[i] = 0; pend_m[i] = 1'b0;
      end else if (pend_m[i]) begin
        if (out_ready) begin
          n_m[i] = 0; tot_m[i] = 0; pend_m[i] = 1'b0;
        end
      end else if (in_valid) begin
        tot_m[i] = tot_m[i] + longint'(in_s) + (in_cout ? 64'd256 : 64'd0);
        n_m[i]++;
        if (n_m[i] == CNT_P[i]) pend_m[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    longint unsigned lim;
    logic [31:0]     exp_sum;
    for (int i = 0; i < 3; i++) begin
      lim = 64'd1 << W_P[i];
      exp_sum = pend_m[i] ? 32'(tot_m[i] % lim) : 32'd0;
      check_val($sformatf("u%0d.in_ready", i), 32'(o_rdy[i]), 32'(!pend_m[i]));
      check_val($sformatf("u%0d.out_valid", i), 32'(o_vld[i]), 32'(pend_m[i]));
      check_val($sformatf("u%0d.out_sum", i), 32'(o_sum[i]), exp_sum);
      check_val($sformatf("u%0d.out_ovf", i), 32'(o_ovf[i]), 32'(pend_m[i] && (tot_m[i] >= lim)));
      check_val($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(pend_m[i] || (n_m[i] != 0)));
    end
  endtask

  // Called at a falling edge; applies inputs, lets one rising edge pass, checks at the next falling edge.
  task automatic step(input logic v, input logic [7:0] s, input logic c, input logic ordy, input logic clr);
    in_valid = v; in_s = s; in_cout = c; out_ready = ordy; clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, 1'b0, ordy, 1'b0);
  endtask

  // Reset is asserted between edges and must take effect without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    check_val("rst.u0.busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_s = 8'h00; in_cout = 1'b0; out_ready = 1'b0;
    model_reset();
    #3 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, back to back, sink always ready.
    step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    check_val("basic.valid", 32'(if0.out_valid), 32'd1);
    check_val("basic.sum", 32'(if0.out_sum), 32'h0160);
    check_val("basic.ovf", 32'(if0.out_ovf), 32'd0);
    check_val("basic.in_ready", 32'(if0.in_ready), 32'd0);
    idle(1'b1);
    check_val("basic.valid_drop", 32'(if0.out_valid), 32'd0);
    check_val("basic.in_ready_back", 32'(if0.in_ready), 32'd1);

    // Gapped input and sink backpressure.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0); idle(1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0); idle(1'b0);
    step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0); idle(1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_val("bp.valid", 32'(if0.out_valid), 32'd1);
      check_val("bp.sum", 32'(if0.out_sum), 32'h0160);
      check_val("bp.in_ready", 32'(if0.in_ready), 32'd0);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b1);
    check_val("bp.idle_busy", 32'(busy[0]), 32'd0);

    // Wrap in the 10-bit accumulator, then a clean frame.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_val("ovf.sum", 32'(if1.out_sum), 32'h3FC);
    check_val("ovf.flag", 32'(if1.out_ovf), 32'd1);
    idle(1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    check_val("ovf2.sum", 32'(if1.out_sum), 32'h004);
    check_val("ovf2.flag", 32'(if1.out_ovf), 32'd0);
    idle(1'b1);

    // Clear mid-frame drops the partial frame and the concurrent accept.
    step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b1, 1'b1);
    check_val("clr.busy", 32'(busy[0]), 32'd0);
    check_val("clr.valid", 32'(if0.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    check_val("clr.sum", 32'(if0.out_sum), 32'h0004);

    // Clear in HOLD beats a same-cycle handshake.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check_val("clrhold.valid", 32'(if0.out_valid), 32'd0);
    check_val("clrhold.busy", 32'(busy[0]), 32'd0);

    // Async reset mid-ACCUM and in HOLD; single-result frames.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    async_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    check_val("cnt1.sum", 32'(if2.out_sum), 32'h00AB);
    check_val("cnt1.valid", 32'(if2.out_valid), 32'd1);
    idle(1'b1);

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
